// File: rtl/beam_pulse_rx_if.sv
// Sample, gate-window and result-handshake bundle for beam_pulse_rx.
// BEAM_PULSE_RX_MISS_EN adds the max_gap / miss signals.
interface beam_pulse_rx_if;
   logic        ena;
   logic [11:0] pulse;
   logic [11:0] window;
   logic        res_ack;
   logic        res_valid;
   logic [11:0] res_count;
   logic [23:0] res_charge;
   logic [11:0] res_min_gap;
   logic [11:0] res_max_gap;
   logic        overrun;
`ifdef BEAM_PULSE_RX_MISS_EN
   logic [11:0] max_gap;
   logic        miss;

   modport master (output ena, pulse, window, res_ack, max_gap,
                   input  res_valid, res_count, res_charge, res_min_gap,
                          res_max_gap, overrun, miss);
   modport slave  (input  ena, pulse, window, res_ack, max_gap,
                   output res_valid, res_count, res_charge, res_min_gap,
                          res_max_gap, overrun, miss);
`else
   modport master (output ena, pulse, window, res_ack,
                   input  res_valid, res_count, res_charge, res_min_gap,
                          res_max_gap, overrun);
   modport slave  (input  ena, pulse, window, res_ack,
                   output res_valid, res_count, res_charge, res_min_gap,
                          res_max_gap, overrun);
`endif
endinterface

// File: rtl/beam_pulse_rx.sv
// Beam pulse analyzer: bunch count, charge and bunch spacing per gate window.
// Optional missing-bunch detector enabled by BEAM_PULSE_RX_MISS_EN.
module beam_pulse_rx (
   input  logic              i_clk,
   input  logic              i_reset,
   beam_pulse_rx_if.slave    bus
);
   typedef enum logic {S_IDLE, S_GATE} state_t;
   localparam logic [11:0] GAP_SAT = 12'hFFF;

   state_t      r_state;
   logic        r_ena;
   logic [11:0] r_pulse;
   logic [11:0] r_window;
   logic        r_prev_nz;
   logic        r_have_gap;
   logic [11:0] r_gap;
   logic [11:0] r_gcnt;
   logic [11:0] r_wlast;
   logic [11:0] r_acc_cnt;
   logic [23:0] r_acc_chg;
   logic [11:0] r_acc_min;
   logic [11:0] r_acc_max;
   logic        r_res_valid;
   logic [11:0] r_res_count;
   logic [23:0] r_res_charge;
   logic [11:0] r_res_min;
   logic [11:0] r_res_max;
   logic        r_overrun;

   logic        w_nz;
   logic        w_start;
   logic        w_active;
   logic        w_end;
   logic        w_rec;
   logic        w_latch;
   logic        w_ack;
   logic [11:0] w_wlast;
   logic [11:0] w_cnt;
   logic [23:0] w_chg;
   logic [11:0] w_min;
   logic [11:0] w_max;

   // Per-sample decode and next accumulator values (r_gcnt is 0 throughout IDLE)
   always_comb begin
      w_nz     = (r_pulse != 12'd0);
      w_start  = w_nz && !r_prev_nz;
      w_active = (r_state == S_GATE) || w_start;
      w_wlast  = (r_gcnt == 12'd0) ? (r_window - 12'd1) : r_wlast;
      w_end    = w_active && (r_gcnt == w_wlast);
      w_rec    = w_start && r_have_gap;
      w_cnt    = r_acc_cnt + 12'(w_start);
      w_chg    = r_acc_chg + 24'(r_pulse);
      w_min    = (w_rec && (r_gap < r_acc_min)) ? r_gap : r_acc_min;
      w_max    = (w_rec && (r_gap > r_acc_max)) ? r_gap : r_acc_max;
      w_latch  = r_ena && w_end;
      w_ack    = bus.res_ack && r_res_valid;
   end

`ifdef BEAM_PULSE_RX_MISS_EN
   logic [11:0] r_max_gap;
   logic        r_miss;
   logic        w_miss_set;

   assign w_miss_set = r_ena && (r_state == S_GATE) && (r_max_gap != 12'd0)
                       && (r_gap > r_max_gap);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_max_gap <= 12'd0;
         r_miss    <= 1'b0;
      end else begin
         r_max_gap <= bus.max_gap;
         r_miss    <= (r_miss && !w_ack) || w_miss_set;
      end
   end

   assign bus.miss = r_miss;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_ena        <= 1'b0;
         r_pulse      <= 12'd0;
         r_window     <= 12'd0;
         r_prev_nz    <= 1'b0;
         r_have_gap   <= 1'b0;
         r_gap        <= 12'd0;
         r_gcnt       <= 12'd0;
         r_wlast      <= 12'd0;
         r_acc_cnt    <= 12'd0;
         r_acc_chg    <= 24'd0;
         r_acc_min    <= GAP_SAT;
         r_acc_max    <= 12'd0;
         r_res_valid  <= 1'b0;
         r_res_count  <= 12'd0;
         r_res_charge <= 24'd0;
         r_res_min    <= GAP_SAT;
         r_res_max    <= 12'd0;
         r_overrun    <= 1'b0;
      end else begin
         r_ena    <= bus.ena;
         r_pulse  <= bus.pulse;
         r_window <= bus.window;

         if (r_ena) begin
            r_prev_nz <= w_nz;
            if (w_start) begin
               r_gap      <= 12'd1;
               r_have_gap <= 1'b1;
            end else if (r_gap != GAP_SAT) begin
               r_gap <= r_gap + 12'd1;
            end

            // Gates run back to back: cycle W-1 latches and reopens at cycle 0
            if (w_active) begin
               r_state <= S_GATE;
               r_wlast <= w_wlast;
               if (w_end) begin
                  r_gcnt    <= 12'd0;
                  r_acc_cnt <= 12'd0;
                  r_acc_chg <= 24'd0;
                  r_acc_min <= GAP_SAT;
                  r_acc_max <= 12'd0;
               end else begin
                  r_gcnt    <= r_gcnt + 12'd1;
                  r_acc_cnt <= w_cnt;
                  r_acc_chg <= w_chg;
                  r_acc_min <= w_min;
                  r_acc_max <= w_max;
               end
            end
         end

         // A coincident ack retires the old result, so the new one is no overrun
         if (w_latch) begin
            r_res_valid  <= 1'b1;
            r_res_count  <= w_cnt;
            r_res_charge <= w_chg;
            r_res_min    <= w_min;
            r_res_max    <= w_max;
            r_overrun    <= !w_ack && (r_res_valid || r_overrun);
         end else if (w_ack) begin
            r_res_valid <= 1'b0;
            r_overrun   <= 1'b0;
         end
      end
   end

   assign bus.res_valid   = r_res_valid;
   assign bus.res_count   = r_res_count;
   assign bus.res_charge  = r_res_charge;
   assign bus.res_min_gap = r_res_min;
   assign bus.res_max_gap = r_res_max;
   assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_beam_pulse_rx.sv
// Directed bench for beam_pulse_rx; the miss scenario runs only when
// BEAM_PULSE_RX_MISS_EN is defined.
module tb_beam_pulse_rx;
   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   beam_pulse_rx_if bus ();
   beam_pulse_rx dut (.i_clk(clk), .i_reset(rst), .bus(bus));

   // {valid, overrun, count, charge, min_gap, max_gap}
   logic [61:0] w_res;
   assign w_res = {bus.res_valid, bus.overrun, bus.res_count, bus.res_charge,
                   bus.res_min_gap, bus.res_max_gap};

   task automatic drive(input logic [11:0] p, input logic a);
      bus.pulse   = p;
      bus.res_ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [11:0] w);
      rst         = 1'b1;
      bus.ena     = 1'b1;
      bus.pulse   = 12'd0;
      bus.res_ack = 1'b0;
      bus.window  = w;
`ifdef BEAM_PULSE_RX_MISS_EN
      bus.max_gap = 12'd0;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [61:0] exp;
      do_reset(12'd10);
      exp = {1'b0, 1'b0, 12'd0, 24'd0, 12'hFFF, 12'd0};
      if (w_res !== exp) begin $display("FAIL reset_vals got %h want %h", w_res, exp); n_bad++; end
      n_vec++;
`ifdef BEAM_PULSE_RX_MISS_EN
      if (bus.miss !== 1'b0) begin $display("FAIL reset_miss got %b want 0", bus.miss); n_bad++; end
      n_vec++;
`endif
   endtask

   task automatic test_periodic();
      logic [61:0] exp;
      logic [11:0] p;
      do_reset(12'd1000);
      exp = {1'b1, 1'b0, 12'd10, 24'd1000, 12'd100, 12'd100};
      for (int n = 0; n <= 2000; n++) begin
         p = (n % 100 == 0) ? 12'd100 : 12'd0;
         drive(p, n == 1001);
         if (n == 999) begin
            if (bus.res_valid !== 1'b0) begin $display("FAIL periodic_early got %b want 0", bus.res_valid); n_bad++; end
            n_vec++;
         end
         if (n == 1000 || n == 2000) begin
            if (w_res !== exp) begin $display("FAIL periodic_gate n=%0d got %h want %h", n, w_res, exp); n_bad++; end
            n_vec++;
         end
         if (n == 1001) begin
            if ({bus.res_valid, bus.overrun} !== 2'b00) begin
               $display("FAIL periodic_ack got %b want 00", {bus.res_valid, bus.overrun}); n_bad++;
            end
            n_vec++;
         end
      end
   endtask

   task automatic test_bunch_pairs();
      int          starts [13];
      int          pos;
      int          sum;
      logic [61:0] exp;
      logic [11:0] p;
      starts[0] = 0;
      for (int i = 1; i < 13; i++) starts[i] = starts[i-1] + ((i - 1 < 7) ? 102 : 101);
      do_reset(12'd1320);
      sum = 0;
      exp = {1'b1, 1'b0, 12'd13, 24'd1300, 12'd101, 12'd102};
      for (int n = 0; n <= 2640; n++) begin
         pos = n % 1320;
         p   = 12'd0;
         for (int i = 0; i < 13; i++) begin
            if (pos == starts[i])     p = 12'd60;
            if (pos == starts[i] + 1) p = 12'd40;
         end
         if (n >= 1320 && n < 2640) sum += int'(p);
         drive(p, 1'b0);
         if (n == 1320) begin
            if (w_res !== exp) begin $display("FAIL pairs_gate1 got %h want %h", w_res, exp); n_bad++; end
            n_vec++;
         end
         if (n == 2640) begin
            if (bus.res_charge !== 24'(sum)) begin $display("FAIL pairs_charge got %0d want %0d", bus.res_charge, sum); n_bad++; end
            n_vec++;
            if ({bus.res_count, bus.res_min_gap, bus.res_max_gap} !== {12'd13, 12'd101, 12'd102}) begin
               $display("FAIL pairs_gate2 got %0d/%0d/%0d want 13/101/102",
                        bus.res_count, bus.res_min_gap, bus.res_max_gap); n_bad++;
            end
            n_vec++;
         end
      end
   endtask

   task automatic test_overrun();
      logic [61:0] exp;
      logic [11:0] p;
      do_reset(12'd200);
      for (int n = 0; n <= 401; n++) begin
         p = (n % 50 == 0) ? 12'd10 : 12'd0;
         drive(p, n == 401);
         if (n == 200 || n == 400) begin
            exp = {1'b1, (n == 400), 12'd4, 24'd40, 12'd50, 12'd50};
            if (w_res !== exp) begin $display("FAIL overrun_n%0d got %h want %h", n, w_res, exp); n_bad++; end
            n_vec++;
         end
         if (n == 401) begin
            if ({bus.res_valid, bus.overrun} !== 2'b00) begin
               $display("FAIL overrun_ack got %b want 00", {bus.res_valid, bus.overrun}); n_bad++;
            end
            n_vec++;
         end
      end
   endtask

   task automatic test_ack_same_cycle();
      logic [61:0] exp;
      logic [11:0] p;
      do_reset(12'd200);
      for (int n = 0; n <= 400; n++) begin
         p = (n % 50 != 0) ? 12'd0 : ((n < 200) ? 12'd10 : 12'd20);
         drive(p, n == 400);
         if (n == 200 || n == 400) begin
            exp = {1'b1, 1'b0, 12'd4, (n == 400) ? 24'd80 : 24'd40, 12'd50, 12'd50};
            if (w_res !== exp) begin $display("FAIL ack_same_n%0d got %h want %h", n, w_res, exp); n_bad++; end
            n_vec++;
         end
      end
   endtask

   task automatic test_boundary();
      logic [61:0] exp;
      logic [11:0] p;
      do_reset(12'd10);
      for (int n = 0; n <= 20; n++) begin
         p = (n == 0) ? 12'd5 : (n == 9) ? 12'd7 : (n == 10) ? 12'd11 : 12'd0;
         drive(p, 1'b0);
         if (n == 9) begin
            if (bus.res_valid !== 1'b0) begin $display("FAIL boundary_early got %b want 0", bus.res_valid); n_bad++; end
            n_vec++;
         end
         if (n == 10 || n == 20) begin
            exp = (n == 10) ? {1'b1, 1'b0, 12'd2, 24'd12, 12'd9, 12'd9}
                            : {1'b1, 1'b1, 12'd0, 24'd11, 12'hFFF, 12'd0};
            if (w_res !== exp) begin $display("FAIL boundary_n%0d got %h want %h", n, w_res, exp); n_bad++; end
            n_vec++;
         end
      end
   endtask

   task automatic test_enable();
      logic [61:0] exp;
      do_reset(12'd10);
      drive(12'd5, 1'b0);
      repeat (3) drive(12'd0, 1'b0);
      bus.ena = 1'b0;
      repeat (5) drive(12'd99, 1'b0);
      bus.ena = 1'b1;
      repeat (6) drive(12'd0, 1'b0);
      if (bus.res_valid !== 1'b0) begin $display("FAIL enable_early got %b want 0", bus.res_valid); n_bad++; end
      n_vec++;
      bus.ena = 1'b0;
      drive(12'd0, 1'b0);
      exp = {1'b1, 1'b0, 12'd1, 24'd5, 12'hFFF, 12'd0};
      if (w_res !== exp) begin $display("FAIL enable_gate got %h want %h", w_res, exp); n_bad++; end
      n_vec++;
      drive(12'd0, 1'b1);
      if (bus.res_valid !== 1'b0) begin $display("FAIL enable_ack got %b want 0", bus.res_valid); n_bad++; end
      n_vec++;
      bus.ena = 1'b1;
   endtask

   task automatic test_reset_mid_gate();
      logic [61:0] exp;
      logic [11:0] p;
      do_reset(12'd1000);
      for (int n = 0; n <= 1500; n++) begin
         p = (n % 100 == 0) ? 12'd100 : 12'd0;
         drive(p, 1'b0);
         if (n == 1000) begin
            if (bus.res_valid !== 1'b1) begin $display("FAIL midreset_pre got %b want 1", bus.res_valid); n_bad++; end
            n_vec++;
         end
      end
      do_reset(12'd10);
      exp = {1'b0, 1'b0, 12'd0, 24'd0, 12'hFFF, 12'd0};
      if (w_res !== exp) begin $display("FAIL midreset_vals got %h want %h", w_res, exp); n_bad++; end
      n_vec++;
      repeat (20) drive(12'd0, 1'b0);
      if (bus.res_valid !== 1'b0) begin $display("FAIL midreset_idle got %b want 0", bus.res_valid); n_bad++; end
      n_vec++;
      for (int k = 0; k <= 10; k++) drive((k == 0) ? 12'd33 : 12'd0, 1'b0);
      exp = {1'b1, 1'b0, 12'd1, 24'd33, 12'hFFF, 12'd0};
      if (w_res !== exp) begin $display("FAIL midreset_gate got %h want %h", w_res, exp); n_bad++; end
      n_vec++;
   endtask

`ifdef BEAM_PULSE_RX_MISS_EN
   task automatic test_miss();
      logic [61:0] exp;
      logic [11:0] p;
      do_reset(12'd1000);
      bus.max_gap = 12'd150;
      exp = {1'b1, 1'b0, 12'd9, 24'd900, 12'd100, 12'd200};
      for (int n = 0; n <= 1001; n++) begin
         p = (n % 100 == 0 && n != 300) ? 12'd100 : 12'd0;
         drive(p, n == 1001);
         if (n == 351 || n == 352 || n == 1000 || n == 1001) begin
            if (bus.miss !== (n == 352 || n == 1000)) begin
               $display("FAIL miss_n%0d got %b want %b", n, bus.miss, (n == 352 || n == 1000)); n_bad++;
            end
            n_vec++;
         end
         if (n == 1000) begin
            if (w_res !== exp) begin $display("FAIL miss_gate got %h want %h", w_res, exp); n_bad++; end
            n_vec++;
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_periodic();
      test_bunch_pairs();
      test_overrun();
      test_ack_same_cycle();
      test_boundary();
      test_enable();
      test_reset_mid_gate();
`ifdef BEAM_PULSE_RX_MISS_EN
      test_miss();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
